// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_reset_pkg                                                        |
// | Shared state encoding and default timing constants for the staged   |
// | PLL reset sequencer.                                                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOCK_FILTER_DEF = 8;
  localparam int HOLD_CYCLES_DEF = 1024;
  localparam int STAGE_GAP_DEF   = 16;
  localparam int LOSS_CNT_W      = 8;

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff                                                             |
// | 1-bit two-flop synchronizer, synchronous active-high reset to 0.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_reset_sequencer                                                  |
// | Filters PLL lock, then releases staged resets in order; any lock    |
// | loss or software request re-asserts all stages and re-sequences.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int LOCK_FILTER = LOCK_FILTER_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int STAGE_GAP   = STAGE_GAP_DEF,
  parameter int N_STAGES    = 3,
  parameter int CNT_W       = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lock,
  input  logic                  sw_rst_req,
  output logic [N_STAGES-1:0]   rst_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int S_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0]      c_lf_last   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0]      c_hold_last = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      c_gap_last  = CNT_W'(STAGE_GAP - 1);
  localparam logic [S_W-1:0]        c_last_stg  = S_W'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0]   c_one       = N_STAGES'(1);
  localparam logic [LOSS_CNT_W-1:0] c_loss_max  = '1;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [S_W-1:0]          r_stage, w_stage_nxt;
  logic [N_STAGES-1:0]     r_rst_out, w_rst_nxt;
  logic                    r_ready, w_ready_nxt;
  logic [LOSS_CNT_W-1:0]   r_loss_cnt, w_loss_nxt;
  logic                    w_lock_s;
  logic                    w_abort;
  logic [S_W-1:0]          w_stage_inc;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (lock),
    .q     (w_lock_s)
  );

  assign w_abort     = (r_state != WAIT_LOCK) && (!w_lock_s || sw_rst_req);
  assign w_stage_inc = r_stage + S_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_rst_nxt   = r_rst_out;
    w_ready_nxt = r_ready;
    w_loss_nxt  = r_loss_cnt;

    case (r_state)
      WAIT_LOCK: begin
        if (sw_rst_req || !w_lock_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_lf_last) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (r_cnt == c_hold_last) begin
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
          w_rst_nxt   = r_rst_out & ~c_one;
          if (N_STAGES == 1) begin
            w_state_nxt = RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (r_cnt == c_gap_last) begin
          w_cnt_nxt   = '0;
          w_stage_nxt = w_stage_inc;
          w_rst_nxt   = r_rst_out & ~(c_one << w_stage_inc);
          if (w_stage_inc == c_last_stg) begin
            w_state_nxt = RUN;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        w_rst_nxt   = '0;
        w_ready_nxt = 1'b1;
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase

    // A lock drop coinciding with a software request is one lock-loss event.
    if (w_abort) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
      w_rst_nxt   = '1;
      w_ready_nxt = 1'b0;
      if (!w_lock_s && (r_loss_cnt != c_loss_max)) begin
        w_loss_nxt = r_loss_cnt + LOSS_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_rst_out  <= '1;
      r_ready    <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_stage    <= w_stage_nxt;
      r_rst_out  <= w_rst_nxt;
      r_ready    <= w_ready_nxt;
      r_loss_cnt <= w_loss_nxt;
    end
  end

  assign rst_out         = r_rst_out;
  assign ready           = r_ready;
  assign lock_loss_count = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pll_reset_sequencer                                               |
// | Scoreboard bench: every output change is matched against a queued   |
// | expectation holding the absolute edge number and output values.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pll_reset_sequencer;

  localparam int LF = 4;
  localparam int HC = 8;
  localparam int SG = 2;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          lock;
  logic          sw_rst_req;
  logic [NS-1:0] rst_out;
  logic          ready;
  logic [7:0]    lock_loss_count;

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       rdy;
    logic [7:0] cnt;
  } exp_t;

  exp_t       q[$];
  exp_t       e_mon;
  exp_t       e_drn;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_on = 1'b0;
  logic [2:0] p_rst;
  logic       p_rdy;
  logic [7:0] p_cnt;
  int         model_cnt;
  int         p;

  pll_reset_sequencer #(
    .LOCK_FILTER (LF),
    .HOLD_CYCLES (HC),
    .STAGE_GAP   (SG),
    .N_STAGES    (NS),
    .CNT_W       (11)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lock            (lock),
    .sw_rst_req      (sw_rst_req),
    .rst_out         (rst_out),
    .ready           (ready),
    .lock_loss_count (lock_loss_count)
  );

  always #10 clk = ~clk;

  // Monitor: any change in the output tuple must match the head of the queue.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_on && (rst_out !== p_rst || ready !== p_rdy || lock_loss_count !== p_cnt)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cycle %0d: rst_out=%b ready=%b count=%0d, none expected",
                   cyc, rst_out, ready, lock_loss_count);
        end else begin
          e_mon = q.pop_front();
          if (e_mon.cyc != cyc || e_mon.rst !== rst_out || e_mon.rdy !== ready ||
              e_mon.cnt !== lock_loss_count) begin
            errors++;
            $display("FAIL event: got cycle %0d rst_out=%b ready=%b count=%0d, want cycle %0d rst_out=%b ready=%b count=%0d",
                     cyc, rst_out, ready, lock_loss_count, e_mon.cyc, e_mon.rst, e_mon.rdy, e_mon.cnt);
          end
        end
      end
      p_rst = rst_out;
      p_rdy = ready;
      p_cnt = lock_loss_count;
    end
  end

  task automatic expect_at(input int c, input logic [2:0] r, input logic d, input logic [7:0] n);
    exp_t e;
    e.cyc = c;
    e.rst = r;
    e.rdy = d;
    e.cnt = n;
    q.push_back(e);
  endtask

  // Full release: stage 0 at c0, then one stage every SG edges, ready with the last.
  task automatic expect_seq(input int c0, input logic [7:0] n);
    expect_at(c0,          3'b110, 1'b0, n);
    expect_at(c0 + SG,     3'b100, 1'b0, n);
    expect_at(c0 + 2 * SG, 3'b000, 1'b1, n);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int n, input string tag);
    cycles(n);
    while (q.size() > 0) begin
      e_drn = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing event: want cycle %0d rst_out=%b ready=%b count=%0d, got no change (now cycle %0d)",
               tag, e_drn.cyc, e_drn.rst, e_drn.rdy, e_drn.cnt, cyc);
    end
  endtask

  task automatic check_now(input string name, input logic [2:0] r, input logic d, input logic [7:0] n);
    checks++;
    if (rst_out !== r || ready !== d || lock_loss_count !== n) begin
      errors++;
      $display("FAIL %s: got rst_out=%b ready=%b count=%0d, want rst_out=%b ready=%b count=%0d",
               name, rst_out, ready, lock_loss_count, r, d, n);
    end
  endtask

  initial begin
    reset      = 1'b1;
    lock       = 1'b0;
    sw_rst_req = 1'b0;
    cycles(5);
    reset = 1'b0;
    check_now("reset_state", 3'b111, 1'b0, 8'd0);
    mon_on = 1'b1;

    // Nominal release; edge 1 is the first edge sampling lock=1.
    cycles(10);
    lock = 1'b1;
    expect_seq(cyc + 14, 8'd0);
    drain(25, "nominal");

    reset = 1'b1;
    lock  = 1'b0;
    expect_at(cyc + 1, 3'b111, 1'b0, 8'd0);
    cycles(2);
    reset = 1'b0;
    cycles(3);

    // Filter restart: 3-cycle pulse must not reach HOLD.
    lock = 1'b1;
    cycles(3);
    lock = 1'b0;
    cycles(1);
    lock = 1'b1;
    expect_seq(cyc + 14, 8'd0);
    drain(25, "filter_restart");

    // Lock loss in RUN, then full re-sequence.
    lock = 1'b0;
    expect_at(cyc + 3, 3'b111, 1'b0, 8'd1);
    cycles(5);
    lock = 1'b1;
    expect_seq(cyc + 14, 8'd1);
    drain(25, "loss_in_run");

    // Abort mid-RELEASE: lock_s falls one edge after stage 0 releases.
    lock = 1'b0;
    expect_at(cyc + 3, 3'b111, 1'b0, 8'd2);
    cycles(5);
    lock = 1'b1;
    p = cyc;
    expect_at(p + 14, 3'b110, 1'b0, 8'd2);
    expect_at(p + 15, 3'b111, 1'b0, 8'd3);
    cycles(12);
    lock = 1'b0;
    cycles(6);
    lock = 1'b1;
    expect_seq(cyc + 14, 8'd3);
    drain(25, "abort_release");

    // Software request in RUN: not counted, re-sequences with lock held.
    sw_rst_req = 1'b1;
    p = cyc;
    expect_at(p + 1, 3'b111, 1'b0, 8'd3);
    expect_seq(p + 13, 8'd3);
    cycles(1);
    sw_rst_req = 1'b0;
    drain(25, "sw_req");

    // Software request on the edge lock_s falls: counted once.
    lock = 1'b0;
    p = cyc;
    expect_at(p + 3, 3'b111, 1'b0, 8'd4);
    cycles(2);
    sw_rst_req = 1'b1;
    cycles(1);
    sw_rst_req = 1'b0;
    drain(5, "sw_and_loss");

    // Saturation: 260 aborts from HOLD.
    model_cnt = 4;
    for (int i = 0; i < 260; i++) begin
      lock = 1'b1;
      p = cyc;
      cycles(6);
      lock = 1'b0;
      if (model_cnt < 255) begin
        model_cnt++;
        expect_at(p + 9, 3'b111, 1'b0, 8'(model_cnt));
      end
      cycles(6);
    end
    drain(2, "saturation");
    check_now("saturated_count", 3'b111, 1'b0, 8'd255);

    // Reset asserted while in HOLD.
    lock = 1'b1;
    p = cyc;
    expect_at(p + 9, 3'b111, 1'b0, 8'd0);
    cycles(8);
    reset = 1'b1;
    lock  = 1'b0;
    cycles(1);
    check_now("reset_mid_hold", 3'b111, 1'b0, 8'd0);
    reset = 1'b0;
    drain(10, "reset_mid_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
